// File: rtl/rip_mem_loader_pkg.sv
// Shared types and constants for the stream-to-memory loader.
package rip_mem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WRITE,
        CHECK,
        DONE
    } loader_state_t;

    localparam int LOADER_LEN_BYTES = 4;
    localparam int LOADER_BYTE_W    = 8;

endpackage

// File: rtl/rip_mem_loader_if.sv
// Byte-stream input and memory write port of the loader; master is the loader side.
interface rip_mem_loader_if #(
    parameter int NUM_COL   = 4,
    parameter int COL_WIDTH = 8
);
    localparam int DATA_WIDTH = NUM_COL * COL_WIDTH;

    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [NUM_COL-1:0]    mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/rip_mem_loader_byte_packer.sv
// Gathers bytes little-endian into one word, tracking which lanes have been filled.
module rip_mem_loader_byte_packer #(
    parameter int NUM_COL   = 4,
    parameter int COL_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           clear_i,
    input  logic                           take_i,
    input  logic [COL_WIDTH-1:0]           byte_i,
    output logic [NUM_COL*COL_WIDTH-1:0]   word_d_o,
    output logic [NUM_COL-1:0]             en_d_o,
    output logic                           last_lane_o
);
    localparam int LANE_W = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;

    logic [LANE_W-1:0]            lane_q, lane_d;
    logic [NUM_COL*COL_WIDTH-1:0] word_q, word_d;
    logic [NUM_COL-1:0]           en_q, en_d;

    assign last_lane_o = (lane_q == LANE_W'(NUM_COL - 1));

    always_comb begin
        word_d = word_q;
        en_d   = en_q;
        lane_d = lane_q;
        if (clear_i) begin
            word_d = '0;
            en_d   = '0;
            lane_d = '0;
        end else if (take_i) begin
            for (int i = 0; i < NUM_COL; i++) begin
                if (lane_q == LANE_W'(i)) begin
                    word_d[i*COL_WIDTH +: COL_WIDTH] = byte_i;
                    en_d[i]                          = 1'b1;
                end
            end
            lane_d = last_lane_o ? '0 : lane_q + LANE_W'(1);
        end
    end

    // The top latches the next-state view so the write strobe lands one cycle after the last byte.
    assign word_d_o = word_d;
    assign en_d_o   = en_d;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            word_q <= '0;
            en_q   <= '0;
            lane_q <= '0;
        end else begin
            word_q <= word_d;
            en_q   <= en_d;
            lane_q <= lane_d;
        end
    end

endmodule

// File: rtl/rip_mem_loader.sv
// Length-prefixed byte-stream loader issuing word writes into memory while holding the CPU busy.
// Optional trailing XOR checksum byte is enabled with `define RIP_LOADER_CHECKSUM_EN.
module rip_mem_loader
    import rip_mem_loader_pkg::*;
#(
    parameter int          NUM_COL    = 4,
    parameter int          COL_WIDTH  = 8,
    parameter int          ADDR_WIDTH = 20,
    parameter int          DATA_WIDTH = NUM_COL * COL_WIDTH,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start,
    rip_mem_loader_if.master         bus,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);
    localparam logic [63:0] MEM_BYTES = 64'(NUM_COL) << ADDR_WIDTH;
    localparam logic [63:0] LEN_LIMIT = MEM_BYTES - 64'(BASE_ADDR);
    localparam int          HDR_W     = $clog2(LOADER_LEN_BYTES);

`ifdef RIP_LOADER_CHECKSUM_EN
    localparam loader_state_t PAYLOAD_END = CHECK;
`else
    localparam loader_state_t PAYLOAD_END = DONE;
`endif

    loader_state_t         state_q;
    logic                  rx_ready_q, busy_q, done_q, err_q;
    logic [NUM_COL-1:0]    mem_we_q;
    logic [DATA_WIDTH-1:0] mem_addr_q, mem_wdata_q;
    logic [HDR_W-1:0]      hdr_cnt_q;
    logic [23:0]           len_q;
    logic [31:0]           rem_q;
`ifdef RIP_LOADER_CHECKSUM_EN
    logic [LOADER_BYTE_W-1:0] csum_q;
`endif

    logic                  fire, take, clear, last_lane, in_range;
    logic [31:0]           len_shift;
    logic [DATA_WIDTH-1:0] word_d;
    logic [NUM_COL-1:0]    en_d;

    assign fire      = bus.rx_valid && rx_ready_q;
    assign take      = fire && (state_q == DATA);
    assign clear     = (state_q == WRITE) || (start && (state_q == IDLE || state_q == DONE));
    assign len_shift = {bus.rx_data, len_q};
    assign in_range  = (64'(mem_addr_q) < MEM_BYTES);

    rip_mem_loader_byte_packer #(
        .NUM_COL   (NUM_COL),
        .COL_WIDTH (COL_WIDTH)
    ) u_packer (
        .clk         (clk),
        .rstn        (rstn),
        .clear_i     (clear),
        .take_i      (take),
        .byte_i      (COL_WIDTH'(bus.rx_data)),
        .word_d_o    (word_d),
        .en_d_o      (en_d),
        .last_lane_o (last_lane)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            rx_ready_q  <= 1'b0;
            mem_we_q    <= '0;
            mem_addr_q  <= DATA_WIDTH'(BASE_ADDR);
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            hdr_cnt_q   <= '0;
            len_q       <= '0;
            rem_q       <= '0;
`ifdef RIP_LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            mem_we_q <= '0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q    <= LEN;
                        rx_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        mem_addr_q <= DATA_WIDTH'(BASE_ADDR);
                        hdr_cnt_q  <= '0;
                        len_q      <= '0;
`ifdef RIP_LOADER_CHECKSUM_EN
                        csum_q     <= '0;
`endif
                    end
                end
                LEN: begin
                    if (fire) begin
                        len_q     <= len_shift[31:8];
                        hdr_cnt_q <= hdr_cnt_q + HDR_W'(1);
                        if (hdr_cnt_q == HDR_W'(LOADER_LEN_BYTES - 1)) begin
                            rem_q <= len_shift;
                            // Oversized loads still drain the stream; out-of-range words just skip the strobe.
                            if ({32'h0, len_shift} > LEN_LIMIT) err_q <= 1'b1;
                            if (len_shift == 32'h0) begin
                                state_q    <= PAYLOAD_END;
                                rx_ready_q <= (PAYLOAD_END == CHECK);
                                busy_q     <= (PAYLOAD_END == CHECK);
                                done_q     <= (PAYLOAD_END == DONE);
                            end else begin
                                state_q <= DATA;
                            end
                        end
                    end
                end
                DATA: begin
                    if (fire) begin
                        rem_q <= rem_q - 32'd1;
`ifdef RIP_LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ bus.rx_data;
`endif
                        if (rem_q == 32'd1 || last_lane) begin
                            state_q     <= WRITE;
                            rx_ready_q  <= 1'b0;
                            mem_we_q    <= in_range ? en_d : '0;
                            mem_wdata_q <= word_d;
                        end
                    end
                end
                WRITE: begin
                    mem_addr_q <= mem_addr_q + DATA_WIDTH'(NUM_COL);
                    if (rem_q != 32'd0) begin
                        state_q    <= DATA;
                        rx_ready_q <= 1'b1;
                    end else begin
                        state_q    <= PAYLOAD_END;
                        rx_ready_q <= (PAYLOAD_END == CHECK);
                        busy_q     <= (PAYLOAD_END == CHECK);
                        done_q     <= (PAYLOAD_END == DONE);
                    end
                end
`ifdef RIP_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (fire) begin
                        if (bus.rx_data != csum_q) err_q <= 1'b1;
                        state_q    <= DONE;
                        rx_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q    <= IDLE;
                    rx_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_ready  = rx_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_rip_mem_loader.sv
// Directed table-driven bench for rip_mem_loader with a 16-byte target memory (ADDR_WIDTH=2).
module tb_rip_mem_loader;

    logic clk = 1'b0;
    logic rstn;
    logic start;
    logic busy, done, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rip_mem_loader_if #(.NUM_COL(4), .COL_WIDTH(8)) bus ();

    rip_mem_loader #(
        .NUM_COL    (4),
        .COL_WIDTH  (8),
        .ADDR_WIDTH (2),
        .BASE_ADDR  (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] data;
    } wr_t;

    wr_t wq[$];

    typedef struct {
        int               len;
        logic [7:0]       pbase;
        logic [7:0]       pstep;
        bit               toggle;
        bit               exp_err;
        int               nwr;
        logic [4:0][31:0] exp_addr;
        logic [4:0][3:0]  exp_we;
        logic [4:0][31:0] exp_data;
    } vec_t;

    localparam int NVEC = 7;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Capture every write strobe; the stream must be stalled while a write is on the bus.
    always @(negedge clk) begin
        if (bus.mem_we !== 4'b0000) begin
            wq.push_back('{addr: bus.mem_addr, we: bus.mem_we, data: bus.mem_wdata});
            check("rx_ready_low_in_write", 64'(bus.rx_ready), 64'd0);
        end
    end

    task automatic set_vec(input int i, input int len, input logic [7:0] pbase, input logic [7:0] pstep,
                           input bit toggle, input bit exp_err, input int nwr);
        vecs[i].len      = len;
        vecs[i].pbase    = pbase;
        vecs[i].pstep    = pstep;
        vecs[i].toggle   = toggle;
        vecs[i].exp_err  = exp_err;
        vecs[i].nwr      = nwr;
        vecs[i].exp_addr = '0;
        vecs[i].exp_we   = '0;
        vecs[i].exp_data = '0;
    endtask

    task automatic set_wr(input int i, input int w, input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
        vecs[i].exp_addr[w] = a;
        vecs[i].exp_we[w]   = we;
        vecs[i].exp_data[w] = d;
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int waited = 0;
        if (gap) begin
            bus.rx_valid = 1'b0;
            @(negedge clk);
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (!bus.rx_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.rx_ready) begin
            check("rx_ready_timeout", 64'd0, 64'd1);
        end else begin
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_header(input logic [31:0] len, input bit gap);
        for (int k = 0; k < 4; k++) send_byte(len[8*k +: 8], gap);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("done_within_budget", 64'(done), 64'd1);
    endtask

    task automatic run_vec(input int v);
        logic [7:0] b;
        logic [7:0] cs;
        cs = 8'h00;
        wq.delete();
        pulse_start();
        check($sformatf("v%0d_busy_after_start", v), 64'(busy), 64'd1);
        check($sformatf("v%0d_done_after_start", v), 64'(done), 64'd0);
        send_header(32'(vecs[v].len), vecs[v].toggle);
        for (int k = 0; k < vecs[v].len; k++) begin
            b  = vecs[v].pbase + 8'(k) * vecs[v].pstep;
            cs = cs ^ b;
            send_byte(b, vecs[v].toggle);
        end
`ifdef RIP_LOADER_CHECKSUM_EN
        send_byte(cs, vecs[v].toggle);
`endif
        wait_done();
        check($sformatf("v%0d_busy_at_done", v), 64'(busy), 64'd0);
        check($sformatf("v%0d_err", v), 64'(err), 64'(vecs[v].exp_err));
        check($sformatf("v%0d_write_count", v), 64'(wq.size()), 64'(vecs[v].nwr));
        for (int w = 0; w < vecs[v].nwr; w++) begin
            if (w < wq.size()) begin
                check($sformatf("v%0d_w%0d_addr", v, w), 64'(wq[w].addr), 64'(vecs[v].exp_addr[w]));
                check($sformatf("v%0d_w%0d_we", v, w), 64'(wq[w].we), 64'(vecs[v].exp_we[w]));
                check($sformatf("v%0d_w%0d_data", v, w), 64'(wq[w].data), 64'(vecs[v].exp_data[w]));
            end
        end
    endtask

    initial begin
        rstn         = 1'b0;
        start        = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;

        //       idx len pbase  pstep  tog err nwr
        set_vec(0, 8,  8'h01, 8'h01, 0, 0, 2);
        set_wr (0, 0, 32'h0, 4'b1111, 32'h0403_0201);
        set_wr (0, 1, 32'h4, 4'b1111, 32'h0807_0605);
        set_vec(1, 5,  8'hAA, 8'h11, 0, 0, 2);
        set_wr (1, 0, 32'h0, 4'b1111, 32'hDDCC_BBAA);
        set_wr (1, 1, 32'h4, 4'b0001, 32'h0000_00EE);
        set_vec(2, 0,  8'h00, 8'h00, 0, 0, 0);
        set_vec(3, 4,  8'h11, 8'h11, 1, 0, 1);
        set_wr (3, 0, 32'h0, 4'b1111, 32'h4433_2211);
        set_vec(4, 20, 8'h01, 8'h01, 0, 1, 4);
        set_wr (4, 0, 32'h0, 4'b1111, 32'h0403_0201);
        set_wr (4, 1, 32'h4, 4'b1111, 32'h0807_0605);
        set_wr (4, 2, 32'h8, 4'b1111, 32'h0C0B_0A09);
        set_wr (4, 3, 32'hC, 4'b1111, 32'h100F_0E0D);
        set_vec(5, 16, 8'h01, 8'h01, 0, 0, 4);
        set_wr (5, 0, 32'h0, 4'b1111, 32'h0403_0201);
        set_wr (5, 1, 32'h4, 4'b1111, 32'h0807_0605);
        set_wr (5, 2, 32'h8, 4'b1111, 32'h0C0B_0A09);
        set_wr (5, 3, 32'hC, 4'b1111, 32'h100F_0E0D);
        set_vec(6, 6,  8'hF0, 8'h01, 1, 0, 2);
        set_wr (6, 0, 32'h0, 4'b1111, 32'hF3F2_F1F0);
        set_wr (6, 1, 32'h4, 4'b0011, 32'h0000_F5F4);

        repeat (3) @(negedge clk);
        check("rst_rx_ready", 64'(bus.rx_ready), 64'd0);
        check("rst_mem_we", 64'(bus.mem_we), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        rstn = 1'b1;
        @(negedge clk);

        for (int v = 0; v < NVEC; v++) run_vec(v);

        // Empty load: done right after the final header (or checksum) byte, with no write.
        wq.delete();
        pulse_start();
        send_header(32'd0, 1'b0);
`ifdef RIP_LOADER_CHECKSUM_EN
        send_byte(8'h00, 1'b0);
`endif
        check("len0_done_immediate", 64'(done), 64'd1);
        check("len0_busy", 64'(busy), 64'd0);
        check("len0_no_writes", 64'(wq.size()), 64'd0);

        // Reset in the middle of a word: nothing written, outputs back to reset, then a clean reload.
        wq.delete();
        pulse_start();
        send_header(32'd4, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        rstn = 1'b0;
        @(negedge clk);
        check("abort_rx_ready", 64'(bus.rx_ready), 64'd0);
        check("abort_mem_we", 64'(bus.mem_we), 64'd0);
        check("abort_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("abort_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_err", 64'(err), 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("abort_no_writes", 64'(wq.size()), 64'd0);
        run_vec(3);

`ifdef RIP_LOADER_CHECKSUM_EN
        wq.delete();
        pulse_start();
        send_header(32'd2, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        wait_done();
        check("csum_good_err", 64'(err), 64'd0);
        check("csum_good_wdata", 64'(wq.size() > 0 ? wq[0].data : 32'hX), 64'h0000_0201);
        check("csum_good_we", 64'(wq.size() > 0 ? wq[0].we : 4'hX), 64'h3);

        pulse_start();
        send_header(32'd2, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        wait_done();
        check("csum_bad_err", 64'(err), 64'd1);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
